// File: rtl/zle_pkg.sv
// Shared definitions for the zero run-length encoder/decoder pair:
// token layout, run limits, FSM state encodings and datapath select codes.
package zle_pkg;

    localparam int TOK_W   = 5;
    localparam int RUN_BIT = 4;
    localparam int MAX_RUN = 15;
    localparam int LEN_W   = $clog2(MAX_RUN + 1);
    localparam int DATA_W  = 3;

    typedef enum logic {
        S_LIT   = 1'b0,
        S_ZEROS = 1'b1
    } zle_state_e;

    // Datapath update selected by the FSM each cycle.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_IDLE = 3'd1,
        OP_LIT  = 3'd2,
        OP_RUN  = 3'd3,
        OP_ZERO = 3'd4
    } zle_op_e;

endpackage

// File: rtl/zle_dec_dp.sv
// Decoder datapath: remaining-zeros counter, output sample register and the
// malformed-token flag. Optional checking is compiled in with ZLE_DEC_ERR_EN.
module zle_dec_dp
    import zle_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  zle_op_e              op_i,
    input  logic [TOK_W-2:0]     tok_i,
    output logic                 rem_one_o,
    output logic [DATA_W-1:0]    o_d_o,
    output logic                 o_v_o,
    output logic                 err_o
);

    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic              ov_q, ov_d;

    always_comb begin
        rem_d = rem_q;
        od_d  = od_q;
        ov_d  = ov_q;
        case (op_i)
            OP_IDLE: ov_d = 1'b0;
            OP_LIT: begin
                od_d = tok_i[DATA_W-1:0];
                ov_d = 1'b1;
            end
            OP_RUN: begin
                od_d  = '0;
                ov_d  = 1'b1;
                rem_d = tok_i[LEN_W-1:0] - 1'b1;
            end
            OP_ZERO: begin
                od_d  = '0;
                ov_d  = 1'b1;
                rem_d = rem_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            od_q  <= '0;
            ov_q  <= 1'b0;
        end else begin
            rem_q <= rem_d;
            od_q  <= od_d;
            ov_q  <= ov_d;
        end
    end

    assign rem_one_o = (rem_q == LEN_W'(1));
    assign o_d_o     = od_q;
    assign o_v_o     = ov_q;

`ifdef ZLE_DEC_ERR_EN
    logic err_q, err_d;

    // A zero literal should have been sent as a run; bit 3 is reserved in literals.
    always_comb begin
        err_d = err_q;
        if (op_i == OP_LIT && (tok_i[DATA_W-1:0] == '0 || tok_i[TOK_W-2]))
            err_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/zle_dec.sv
// Zero run-length decoder: FSM choosing the datapath update each cycle.
// Define ZLE_DEC_ERR_EN to compile in malformed-token detection on err.
module zle_dec
    import zle_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [TOK_W-1:0]  i_d,
    input  logic              i_v,
    output logic              i_b,
    output logic [DATA_W-1:0] o_d,
    output logic              o_v,
    input  logic              o_b,
    output logic              err
);

    zle_state_e state_q, state_d;
    zle_op_e    op;
    logic       stall, consume, rem_one;
    logic [LEN_W-1:0] run_len;

    assign stall   = o_v & o_b;
    assign i_b     = (state_q == S_ZEROS) | stall;
    assign consume = i_v & ~i_b;
    assign run_len = i_d[LEN_W-1:0];

    always_comb begin
        state_d = state_q;
        op      = OP_HOLD;
        if (!stall) begin
            case (state_q)
                S_LIT: begin
                    op = OP_IDLE;
                    if (consume) begin
                        if (!i_d[RUN_BIT]) begin
                            op = OP_LIT;
                        end else if (run_len != '0) begin
                            op = OP_RUN;
                            // A length-1 run is fully emitted by the RUN update itself.
                            if (run_len > LEN_W'(1)) state_d = S_ZEROS;
                        end
                    end
                end
                S_ZEROS: begin
                    op = OP_ZERO;
                    if (rem_one) state_d = S_LIT;
                end
                default: state_d = S_LIT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_LIT;
        else        state_q <= state_d;
    end

    zle_dec_dp u_dp (
        .clock     (clock),
        .reset     (reset),
        .op_i      (op),
        .tok_i     (i_d[TOK_W-2:0]),
        .rem_one_o (rem_one),
        .o_d_o     (o_d),
        .o_v_o     (o_v),
        .err_o     (err)
    );

endmodule

// File: tb/tb_zle_dec.sv
// Directed table-driven bench for zle_dec, plus hand sequences for reset
// mid-run and the reserved-bit literal.
module tb_zle_dec;
    import zle_pkg::*;

`ifdef ZLE_DEC_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] i_d;
    logic       i_v, i_b, o_v, o_b, err;
    logic [2:0] o_d;

    zle_dec dut (
        .clock (clock), .reset (reset),
        .i_d   (i_d),   .i_v   (i_v),   .i_b (i_b),
        .o_d   (o_d),   .o_v   (o_v),   .o_b (o_b),
        .err   (err)
    );

    always #5 clock = ~clock;

    // Each row is one cycle: inputs driven for that cycle, and the outputs
    // expected to be visible during it (result of earlier rows).
    typedef struct {
        logic [4:0] id;
        logic       iv;
        logic       ob;
        logic       ev;
        logic [2:0] ed;
        logic       eb;
        logic       ee;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic [4:0] id, input logic iv, input logic ob,
                       input logic ev, input logic [2:0] ed, input logic eb,
                       input logic ee);
        vec_t v;
        v.id = id; v.iv = iv; v.ob = ob;
        v.ev = ev; v.ed = ed; v.eb = eb; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; i_d = '0; i_v = 1'b0; o_b = 1'b0;
        #1;
        chk("reset_ov",  int'(o_v), 0);
        chk("reset_od",  int'(o_d), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_ib",  int'(i_b), 0);
        @(posedge clock); @(posedge clock);
        @(negedge clock); reset = 1'b1;

        // literals back to back
        add(5'h05,1,0, 0,0,0,0);
        add(5'h03,1,0, 1,5,0,0);
        add(5'h07,1,0, 1,3,0,0);
        add(5'h00,0,0, 1,7,0,0);
        add(5'h00,0,0, 0,0,0,0);
        // run of 4 then literal 2, literal offered while expanding
        add(5'h14,1,0, 0,0,0,0);
        add(5'h02,1,0, 1,0,1,0);
        add(5'h02,1,0, 1,0,1,0);
        add(5'h02,1,0, 1,0,1,0);
        add(5'h02,1,0, 1,0,0,0);
        add(5'h00,0,0, 1,2,0,0);
        add(5'h00,0,0, 0,0,0,0);
        // maximum run: 15 zeros
        add(5'h1F,1,0, 0,0,0,0);
        for (int k = 0; k < 14; k++) add(5'h00,0,0, 1,0,1,0);
        add(5'h00,0,0, 1,0,0,0);
        add(5'h00,0,0, 0,0,0,0);
        // zero-length run, then literal 1
        add(5'h10,1,0, 0,0,0,0);
        add(5'h01,1,0, 0,0,0,0);
        add(5'h00,0,0, 1,1,0,0);
        add(5'h00,0,0, 0,0,0,0);
        // length-1 run stays in S_LIT
        add(5'h11,1,0, 0,0,0,0);
        add(5'h00,0,0, 1,0,0,0);
        add(5'h00,0,0, 0,0,0,0);
        // run of 3, second zero stalled for 2 cycles
        add(5'h13,1,0, 0,0,0,0);
        add(5'h00,0,0, 1,0,1,0);
        add(5'h00,0,1, 1,0,1,0);
        add(5'h00,0,1, 1,0,1,0);
        add(5'h00,0,0, 1,0,1,0);
        add(5'h00,0,0, 1,0,0,0);
        add(5'h00,0,0, 0,0,0,0);
        // o_b rising with token arrival: token waits
        add(5'h05,1,0, 0,0,0,0);
        add(5'h06,1,1, 1,5,1,0);
        add(5'h06,1,0, 1,5,0,0);
        add(5'h00,0,0, 1,6,0,0);
        add(5'h00,0,0, 0,0,0,0);
        // zero literal: flagged when checking is built in, still emitted
        add(5'h00,1,0, 0,0,0,0);
        add(5'h00,0,0, 1,0,0,ERR_ON);
        add(5'h04,1,0, 0,0,0,ERR_ON);
        add(5'h00,0,0, 1,4,0,ERR_ON);
        add(5'h00,0,0, 0,0,0,ERR_ON);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            i_d = vecs[i].id; i_v = vecs[i].iv; o_b = vecs[i].ob;
            #1;
            chk($sformatf("row%0d", i),
                int'({i_b, o_v, (vecs[i].ev ? o_d : 3'd0), err}),
                int'({vecs[i].eb, vecs[i].ev, (vecs[i].ev ? vecs[i].ed : 3'd0), vecs[i].ee}));
        end

        // reset during a 10-zero run after 3 zeros
        @(negedge clock); i_d = 5'h1A; i_v = 1'b1; o_b = 1'b0;
        #1 chk("run10_ib", int'(i_b), 0);
        @(negedge clock); i_v = 1'b0;
        #1 chk("run10_z1", int'({o_v, o_d}), 8);
        @(negedge clock);
        #1 chk("run10_z2", int'({o_v, o_d, i_b}), 17);
        @(negedge clock);
        #1 chk("run10_z3", int'({o_v, o_d, i_b}), 17);
        reset = 1'b0;
        #1;
        chk("midrst_ov",  int'(o_v), 0);
        chk("midrst_ib",  int'(i_b), 0);
        chk("midrst_err", int'(err), 0);
        @(posedge clock);
        @(negedge clock); reset = 1'b1; i_d = 5'h06; i_v = 1'b1;
        #1 chk("rel_ov_ib", int'({o_v, i_b}), 0);
        @(negedge clock); i_v = 1'b0;
        #1 chk("rel_lit6", int'({o_v, o_d}), 14);
        @(negedge clock);
        #1 chk("rel_idle", int'(o_v), 0);

        // literal with reserved bit 3 set
        @(negedge clock); i_d = 5'h0B; i_v = 1'b1;
        @(negedge clock); i_v = 1'b0;
        #1 chk("rsv_lit", int'({o_v, o_d}), 11);
        chk("rsv_err", int'(err), int'(ERR_ON));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
